sinh_shift_accum: RTL and testbench
===================================

SINH_SHIFT_ACCUM -- requirements
Module: sinh_shift_accum

Interface
REQ-001 Parameter DWIDTH, default 16, SHALL set the data width of iData, the accumulator and sinhOut.
REQ-002 Parameter NTERMS, default 4, range 1..16, SHALL set the number of shifted terms summed per operation.
REQ-003 Parameter SHIFT_LO, default 7, SHALL set the term-0 shift when scomp=0.
REQ-004 Parameter SHIFT_HI, default 4, SHALL set the term-0 shift when scomp=1.
REQ-005 Parameter SHIFT_STEP, default 2, SHALL set the shift increment per term.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rstn  input  1  SHALL be the reset, asynchronous and active-low.
REQ-008 iValid  input  1  SHALL mark a valid operand on iData/scomp.
REQ-009 iReady  output  1  SHALL indicate the block accepts an operand this cycle.
REQ-010 iData  input  DWIDTH  SHALL carry the two's-complement operand.
REQ-011 scomp  input  1  SHALL select the shift base: 1 = SHIFT_HI, 0 = SHIFT_LO.
REQ-012 oValid  output  1  SHALL mark sinhOut as a valid result.
REQ-013 oReady  input  1  SHALL indicate the consumer accepts the result.
REQ-014 sinhOut  output  DWIDTH  SHALL carry the two's-complement result.
REQ-015 busy  output  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ACCUM, HOLD.
REQ-017 iReady SHALL be 1 only in IDLE; oValid SHALL be 1 only in HOLD.
REQ-018 In IDLE, iValid&&iReady at a clock edge SHALL latch iData and scomp, clear accumulator and term index k to 0, and enter ACCUM.
REQ-019 In ACCUM, each edge SHALL add (latched data >>> sh(k)) to the accumulator and increment k, where sh(k) = base + k*SHIFT_STEP and base = SHIFT_HI if latched scomp=1, else SHIFT_LO.
REQ-020 The shift SHALL be arithmetic (sign-filling); any sh(k) >= DWIDTH SHALL yield all sign bits (0 or all-ones).
REQ-021 Accumulation SHALL wrap modulo 2^DWIDTH with no saturation and no overflow flag.
REQ-022 After the edge that adds term NTERMS-1, the FSM SHALL enter HOLD with sinhOut = accumulator; oValid rises exactly NTERMS cycles after the accepting edge.
REQ-023 In HOLD, sinhOut SHALL remain stable until oValid&&oReady at an edge, which SHALL return the FSM to IDLE.
REQ-024 Changes on iData, scomp or iValid outside the accepting edge SHALL have no effect on the result.
REQ-025 No new operand SHALL be accepted in the cycle the result handshakes; the next accept is earliest one cycle later (throughput one result per NTERMS+2 cycles).
REQ-026 oReady while not in HOLD SHALL be ignored.
REQ-027 sinhOut SHALL hold its last result in IDLE and ACCUM (value not guaranteed meaningful while oValid=0).

Reset
REQ-028 rstn low SHALL immediately force FSM to IDLE, k, accumulator and sinhOut to 0, oValid=0, busy=0, iReady=1 after release.
REQ-029 Reset asserted during ACCUM or HOLD SHALL abort the operation with no result delivered.
REQ-030 The first operand SHALL be accepted no earlier than the first rising edge after rstn deasserts.

Verification (DWIDTH=16, NTERMS=4, SHIFT_LO=7, SHIFT_HI=4, SHIFT_STEP=2)
REQ-031 iData=0x4000, scomp=0, oReady=1 -> oValid 4 cycles after accept, sinhOut=0x00AA (128+32+8+2).
REQ-032 iData=0x4000, scomp=1 -> sinhOut=0x0550 (1024+256+64+16).
REQ-033 iData=0xC000, scomp=0 -> sinhOut=0xFF56 (-170); iData=0xFFFF, scomp=0 -> sinhOut=0xFFFC (-4, floor rounding).
REQ-034 oReady held low 3 cycles in HOLD with iData toggling -> sinhOut, oValid stable, iReady=0; completes on first oReady=1 edge, iReady=1 next cycle.
REQ-035 rstn pulsed low during ACCUM term 2 -> all outputs 0, busy=0 immediately; no oValid until a new operand is accepted.
REQ-036 Back-to-back iValid=1 with oReady=1 -> accepts spaced exactly NTERMS+2 cycles apart, each result correct.

Source files
------------

// File: rtl/sinh_shift_accum.sv
// sinh_shift_accum
//   Multi-cycle shift-and-add evaluator. An accepted operand x is summed as
//   x>>>sh(0) + x>>>sh(1) + ... + x>>>sh(NTERMS-1), one term per clock, where
//   sh(k) = base + k*SHIFT_STEP and base is SHIFT_HI (scomp=1) or SHIFT_LO.
//   The sum wraps modulo 2^DWIDTH and is presented with a valid/ready handshake.
//
// Ports
//   clk      in   clock, rising edge
//   rstn     in   asynchronous active-low reset
//   iValid   in   operand valid
//   iReady   out  operand accepted this cycle (IDLE only)
//   iData    in   two's-complement operand, DWIDTH bits
//   scomp    in   shift base select, 1 = SHIFT_HI, 0 = SHIFT_LO
//   oValid   out  result valid (HOLD only)
//   oReady   in   consumer takes the result
//   sinhOut  out  two's-complement result, DWIDTH bits
//   busy     out  FSM not in IDLE
//
// state | meaning
// IDLE  | waiting for an operand, iReady=1
// ACCUM | adding one shifted term per cycle, k = term index
// HOLD  | result on sinhOut, oValid=1 until oReady

module sinh_shift_accum #(
    parameter int DWIDTH     = 16,
    parameter int NTERMS     = 4,
    parameter int SHIFT_LO   = 7,
    parameter int SHIFT_HI   = 4,
    parameter int SHIFT_STEP = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              iValid,
    output logic              iReady,
    input  logic [DWIDTH-1:0] iData,
    input  logic              scomp,
    output logic              oValid,
    input  logic              oReady,
    output logic [DWIDTH-1:0] sinhOut,
    output logic              busy
);

    localparam int KW = (NTERMS > 1) ? $clog2(NTERMS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NTERMS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [KW-1:0]      k;
    logic [DWIDTH-1:0]  acc;
    logic [DWIDTH-1:0]  data_q;
    logic               scomp_q;

    int                 sh_amt;
    logic [DWIDTH-1:0]  term;
    logic [DWIDTH-1:0]  acc_next;

    // Shifts at or past the word width collapse to pure sign fill; the
    // explicit branch avoids relying on out-of-range shift semantics.
    always_comb begin
        sh_amt = (scomp_q ? SHIFT_HI : SHIFT_LO) + int'(k) * SHIFT_STEP;
        term   = '0;
        if (sh_amt >= DWIDTH) begin
            term = {DWIDTH{data_q[DWIDTH-1]}};
        end else begin
            term = DWIDTH'($signed(data_q) >>> sh_amt);
        end
        acc_next = acc + term;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            k       <= '0;
            acc     <= '0;
            data_q  <= '0;
            scomp_q <= 1'b0;
            sinhOut <= '0;
            iReady  <= 1'b1;
            oValid  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iValid && iReady) begin
                        data_q  <= iData;
                        scomp_q <= scomp;
                        acc     <= '0;
                        k       <= '0;
                        state   <= ACCUM;
                        iReady  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    k   <= k + KW'(1);
                    if (k == K_LAST) begin
                        state   <= HOLD;
                        sinhOut <= acc_next;
                        oValid  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (oReady) begin
                        state  <= IDLE;
                        oValid <= 1'b0;
                        iReady <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    oValid <= 1'b0;
                    iReady <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sinh_shift_accum.sv
module tb_sinh_shift_accum;

    localparam int DW = 16;
    localparam int NT = 4;
    localparam int NT2 = 6;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          iValid = 1'b0;
    logic          iReady;
    logic [DW-1:0] iData = '0;
    logic          scomp = 1'b0;
    logic          oValid;
    logic          oReady = 1'b1;
    logic [DW-1:0] sinhOut;
    logic          busy;

    // second instance with enough terms that late shifts reach the word width
    logic          iValid2 = 1'b0;
    logic          iReady2;
    logic [DW-1:0] iData2 = '0;
    logic          oValid2;
    logic [DW-1:0] sinhOut2;
    logic          busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sinh_shift_accum #(.DWIDTH(DW), .NTERMS(NT), .SHIFT_LO(7), .SHIFT_HI(4), .SHIFT_STEP(2)) dut (
        .clk(clk), .rstn(rstn), .iValid(iValid), .iReady(iReady), .iData(iData),
        .scomp(scomp), .oValid(oValid), .oReady(oReady), .sinhOut(sinhOut), .busy(busy)
    );

    sinh_shift_accum #(.DWIDTH(DW), .NTERMS(NT2), .SHIFT_LO(7), .SHIFT_HI(4), .SHIFT_STEP(2)) dut2 (
        .clk(clk), .rstn(rstn), .iValid(iValid2), .iReady(iReady2), .iData(iData2),
        .scomp(1'b0), .oValid(oValid2), .oReady(1'b1), .sinhOut(sinhOut2), .busy(busy2)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sc;
        logic [DW-1:0] exp;
        string         name;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One full operation; hold_cyc = cycles oReady stays low once oValid is up.
    task automatic run_op(input logic [DW-1:0] d, input logic sc, input logic [DW-1:0] exp,
                          input string name, input int hold_cyc);
        int cyc;
        logic [DW-1:0] held;
        @(negedge clk);
        check({name, ".iready_before"}, {31'd0, iReady}, 32'd1);
        iData  = d;
        scomp  = sc;
        iValid = 1'b1;
        oReady = (hold_cyc == 0);
        @(posedge clk);
        #1;
        iValid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            iData = DW'($urandom);
            scomp = $urandom_range(0, 1) == 1;
            iValid = $urandom_range(0, 1) == 1;
            @(posedge clk);
            #1;
            cyc++;
            if (oValid) break;
        end
        iValid = 1'b0;
        check({name, ".latency"}, cyc, NT);
        check({name, ".result"}, {16'd0, sinhOut}, {16'd0, exp});
        check({name, ".busy"}, {31'd0, busy}, 32'd1);
        check({name, ".iready_busy"}, {31'd0, iReady}, 32'd0);
        held = sinhOut;
        for (int h = 0; h < hold_cyc; h++) begin
            iData = DW'($urandom);
            scomp = ~scomp;
            @(posedge clk);
            #1;
            check({name, ".hold_valid"}, {31'd0, oValid}, 32'd1);
            check({name, ".hold_data"}, {16'd0, sinhOut}, {16'd0, held});
            check({name, ".hold_iready"}, {31'd0, iReady}, 32'd0);
        end
        if (hold_cyc != 0) begin
            @(negedge clk);
            oReady = 1'b1;
        end
        @(posedge clk);
        #1;
        check({name, ".done_ovalid"}, {31'd0, oValid}, 32'd0);
        check({name, ".done_iready"}, {31'd0, iReady}, 32'd1);
        check({name, ".done_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int acc_t[3];
        int n_acc;
        int cyc;
        logic seen;

        vecs[0] = '{16'h4000, 1'b0, 16'h00AA, "p4000_lo"};
        vecs[1] = '{16'h4000, 1'b1, 16'h0550, "p4000_hi"};
        vecs[2] = '{16'hC000, 1'b0, 16'hFF56, "nC000_lo"};
        vecs[3] = '{16'hFFFF, 1'b0, 16'hFFFC, "m1_lo_floor"};
        vecs[4] = '{16'h7FFF, 1'b0, 16'h0150, "max_lo"};
        vecs[5] = '{16'h7FFF, 1'b1, 16'h0A9C, "max_hi"};
        vecs[6] = '{16'h8000, 1'b1, 16'hF560, "min_hi"};
        vecs[7] = '{16'h0001, 1'b1, 16'h0000, "one_hi"};
        vecs[8] = '{16'h0100, 1'b0, 16'h0002, "p0100_lo"};

        // reset state
        #12;
        check("rst.ovalid", {31'd0, oValid}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.sinhout", {16'd0, sinhOut}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst.iready_after", {31'd0, iReady}, 32'd1);

        foreach (vecs[i]) run_op(vecs[i].data, vecs[i].sc, vecs[i].exp, vecs[i].name, 0);

        // consumer stalls three cycles with inputs toggling
        run_op(16'h4000, 1'b1, 16'h0550, "stall3", 3);

        // reset while term 2 is being added
        @(negedge clk);
        iData = 16'h4000; scomp = 1'b0; iValid = 1'b1;
        @(posedge clk);
        #1;
        iValid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("abort.ovalid", {31'd0, oValid}, 32'd0);
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.sinhout", {16'd0, sinhOut}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (oValid) seen = 1'b1;
        end
        check("abort.no_result", {31'd0, seen}, 32'd0);

        // back-to-back: iValid held high, accept spacing must be NT+2
        @(negedge clk);
        iData = 16'h4000; scomp = 1'b0; iValid = 1'b1; oReady = 1'b1;
        n_acc = 0;
        cyc = 0;
        while (n_acc < 3 && cyc < 40) begin
            @(negedge clk);
            if (iReady) begin
                acc_t[n_acc] = cyc;
                n_acc++;
            end
            if (oValid) check("b2b.result", {16'd0, sinhOut}, 32'h00AA);
            cyc++;
        end
        iValid = 1'b0;
        check("b2b.accepts", n_acc, 3);
        if (n_acc == 3) begin
            check("b2b.gap1", acc_t[1] - acc_t[0], NT + 2);
            check("b2b.gap2", acc_t[2] - acc_t[1], NT + 2);
        end

        // shifts 15 and 17 on dut2: the 17 must yield pure sign fill
        for (int v = 0; v < 2; v++) begin
            logic [DW-1:0] d2;
            logic [DW-1:0] e2;
            d2 = (v == 0) ? 16'h8000 : 16'h7FFF;
            e2 = (v == 0) ? 16'hFEAA : 16'h0150;
            @(negedge clk);
            iData2 = d2; iValid2 = 1'b1;
            @(posedge clk);
            #1;
            iValid2 = 1'b0;
            cyc = 0;
            while (cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
                if (oValid2) break;
            end
            check("wide.latency", cyc, NT2);
            check("wide.result", {16'd0, sinhOut2}, {16'd0, e2});
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
